osc_meas_ctrl: RTL and testbench
================================

// Module: osc_meas_ctrl
// PURPOSE
// - Sequencer for the ring-oscillator PUF measurement path. For each of N_PAIRS
//   challenge pairs it selects two oscillators onto counters A/B, runs a timed window,
//   stops the rings, latches both counts and compares them into one response bit.
// - Sits between the challenge/response host logic and the oscillator mux + two
//   ripple counters. Runs on the system clock; the counters run on oscillator edges.
// PARAMETERS
// - N_OSC     16  number of ring oscillators; SEL_W = $clog2(N_OSC)
// - N_PAIRS   8   pairs per challenge = response bits
// - C_DWIDTH  24  counter width, matches measurement counter instances
// - C_WIN_W   16  window-length width, in I_clk cycles
// - C_SETTLE  4   cycles for mux settle / ring drain (SEL and STOP states)
// - C_SYNC    3   cycles after count latch before sampling (LATCH state)
// PORTS
// - I_clk       in   1                    system clock
// - I_rst       in   1                    reset, asynchronous, active-low
// - I_start     in   1                    start request, sampled in IDLE only
// - I_chal      in   N_PAIRS*2*SEL_W      pair k: A idx=[2kS+:S], B idx=[2kS+S+:S] (S=SEL_W)
// - I_win_len   in   C_WIN_W              RUN window length in cycles
// - I_cnt_a     in   C_DWIDTH             latched count of counter A
// - I_cnt_b     in   C_DWIDTH             latched count of counter B
// - O_sel_a     out  SEL_W                oscillator index routed to counter A
// - O_sel_b     out  SEL_W                oscillator index routed to counter B
// - O_osc_en    out  N_OSC                one-hot ring enables (bits sel_a|sel_b in RUN)
// - O_cnt_rst_n out  1                    counter reset; falling edge latches count and clears
// - O_busy      out  1                    high from start accept until DONE exits
// - O_valid     out  1                    one-cycle pulse, O_resp/O_tie valid
// - O_resp      out  N_PAIRS              bit k = (cnt_a > cnt_b) for pair k
// - O_tie       out  N_PAIRS              bit k = (cnt_a == cnt_b) for pair k
// BEHAVIOUR
// - Reset: state IDLE; O_sel_*=0, O_osc_en=0, O_cnt_rst_n=0, O_busy=0, O_valid=0,
//   O_resp=0, O_tie=0; pair index 0. Reset mid-run aborts instantly, no O_valid.
// - IDLE: I_start=1 -> latch I_chal and I_win_len (0 treated as 1), k=0, busy=1, ->SEL.
//   I_start while busy is ignored.
// - SEL: drive O_sel_a/b from pair k; osc_en=0, cnt_rst_n=0; C_SETTLE cycles ->RUN.
// - RUN: cnt_rst_n=1, osc_en set for sel_a and sel_b; exactly win_len cycles ->STOP.
// - STOP: osc_en=0, cnt_rst_n=1; C_SETTLE cycles ->LATCH.
// - LATCH: cnt_rst_n=0 (counters latch + clear); C_SYNC cycles ->CMP.
// - CMP: 1 cycle; sample I_cnt_a/b unsigned; resp[k]=a>b, tie[k]=a==b;
//   k==N_PAIRS-1 ->DONE else k++ ->SEL.
// - DONE: O_valid=1 for 1 cycle, O_resp/O_tie hold until next start; ->IDLE, busy=0.
// - sel_a==sel_b: pair still run, single enable bit, counts equal -> resp 0, tie 1.
// - Per-pair latency: C_SETTLE+win_len+C_SETTLE+C_SYNC+1 cycles; total N_PAIRS*that +1.
// - Counter wrap within window is not detected; window sizing is the host's duty.
// - O_sel_*, O_osc_en, O_cnt_rst_n are registered outputs (glitch-free to async logic).
// STRUCTURE
// - Package osc_meas_pkg: state enum {IDLE,SEL,RUN,STOP,LATCH,CMP,DONE},
//   SEL_W function, default C_SETTLE/C_SYNC constants.
// - Sub-module osc_win_timer: loadable down-counter (C_WIN_W), load/expire pulse,
//   shared by SEL/RUN/STOP/LATCH phase timing.
// - Top: FSM, challenge/response shift registers, pair index, comparator.
// TESTING
// - N_PAIRS=2, chal A0/B1,A2/B3, win 10, cnt_a=100/cnt_b=90 then 50/60 -> resp=2'b01, tie=0.
// - win_len=0 -> RUN lasts exactly 1 cycle; win_len=5 -> osc_en high exactly 5 cycles.
// - Pair with sel_a=sel_b=7 -> O_osc_en=16'h0080 in RUN; cnt equal -> resp 0, tie 1.
// - I_rst low during RUN of pair 1 -> osc_en=0, cnt_rst_n=0, busy=0 async; no O_valid.
// - I_start pulses while busy -> ignored; exactly one O_valid per accepted start.
// - Phase timing check: SEL 4, STOP 4, LATCH 3, CMP 1 cycle; O_valid once, width 1.

Source files
------------

// File: rtl/osc_meas_pkg.sv
// +--------------------------------------------------------------------------+
// | osc_meas_pkg : shared types/constants for the RO-PUF measurement path    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package osc_meas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    LATCH = 3'd4,
    CMP   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int C_SETTLE_DEF = 4;
  localparam int C_SYNC_DEF   = 3;

  function automatic int sel_w(input int n_osc);
    return (n_osc > 1) ? $clog2(n_osc) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/osc_win_timer.sv
// +--------------------------------------------------------------------------+
// | osc_win_timer : loadable down-counter timing every measurement phase     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module osc_win_timer #(
  parameter int C_WIN_W = 16
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_load,
  input  logic [C_WIN_W-1:0] I_len,
  output logic               O_expire
);

  logic [C_WIN_W-1:0] r_cnt;

  // Loading N gives N cycles in the new phase; expire marks the last of them.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_cnt <= '0;
    end else if (I_load) begin
      r_cnt <= (I_len == '0) ? '0 : I_len - C_WIN_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_WIN_W'(1);
    end
  end

  assign O_expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/osc_meas_ctrl.sv
// +--------------------------------------------------------------------------+
// | osc_meas_ctrl : RO-PUF pair sequencer (select/run/stop/latch/compare)    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module osc_meas_ctrl
  import osc_meas_pkg::*;
#(
  parameter int  N_OSC    = 16,
  parameter int  N_PAIRS  = 8,
  parameter int  C_DWIDTH = 24,
  parameter int  C_WIN_W  = 16,
  parameter int  C_SETTLE = C_SETTLE_DEF,
  parameter int  C_SYNC   = C_SYNC_DEF,
  localparam int SEL_W    = sel_w(N_OSC)
) (
  input  logic                       I_clk,
  input  logic                       I_rst,
  input  logic                       I_start,
  input  logic [N_PAIRS*2*SEL_W-1:0] I_chal,
  input  logic [C_WIN_W-1:0]         I_win_len,
  input  logic [C_DWIDTH-1:0]        I_cnt_a,
  input  logic [C_DWIDTH-1:0]        I_cnt_b,
  output logic [SEL_W-1:0]           O_sel_a,
  output logic [SEL_W-1:0]           O_sel_b,
  output logic [N_OSC-1:0]           O_osc_en,
  output logic                       O_cnt_rst_n,
  output logic                       O_busy,
  output logic                       O_valid,
  output logic [N_PAIRS-1:0]         O_resp,
  output logic [N_PAIRS-1:0]         O_tie
);

  localparam int                 CH_W         = N_PAIRS * 2 * SEL_W;
  localparam int                 K_W          = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [K_W-1:0]     C_K_LAST     = K_W'(N_PAIRS - 1);
  localparam logic [C_WIN_W-1:0] C_SETTLE_LEN = C_WIN_W'(C_SETTLE);
  localparam logic [C_WIN_W-1:0] C_SYNC_LEN   = C_WIN_W'(C_SYNC);

  state_t               r_state;
  logic [CH_W-1:0]      r_chal;
  logic [C_WIN_W-1:0]   r_win;
  logic [K_W-1:0]       r_k;
  logic [N_PAIRS-1:0]   r_resp_sh;
  logic [N_PAIRS-1:0]   r_tie_sh;

  logic                 w_expire;
  logic                 w_load;
  logic [C_WIN_W-1:0]   w_len;
  logic                 w_last;
  logic                 w_gt;
  logic                 w_eq;
  logic [CH_W-1:0]      w_chal_nxt;
  logic [N_OSC-1:0]     w_en;
  logic [N_PAIRS:0]     w_resp_cat;
  logic [N_PAIRS:0]     w_tie_cat;
  logic [N_PAIRS-1:0]   w_resp_nxt;
  logic [N_PAIRS-1:0]   w_tie_nxt;

  assign w_last     = (r_k == C_K_LAST);
  assign w_gt       = (I_cnt_a > I_cnt_b);
  assign w_eq       = (I_cnt_a == I_cnt_b);
  // The active pair always sits in the low bits of r_chal.
  assign w_chal_nxt = r_chal >> (2 * SEL_W);
  // Equal selects collapse to a single enable bit, which is the wanted behaviour.
  assign w_en       = (N_OSC'(1) << O_sel_a) | (N_OSC'(1) << O_sel_b);
  // Results shift in from the top so pair k ends up in bit k after the last pair.
  assign w_resp_cat = {w_gt, r_resp_sh};
  assign w_tie_cat  = {w_eq, r_tie_sh};
  assign w_resp_nxt = w_resp_cat[N_PAIRS:1];
  assign w_tie_nxt  = w_tie_cat[N_PAIRS:1];

  always_comb begin
    w_load = 1'b0;
    w_len  = C_SETTLE_LEN;
    case (r_state)
      IDLE:    w_load = I_start;
      SEL: begin
        w_load = w_expire;
        w_len  = r_win;
      end
      RUN:     w_load = w_expire;
      STOP: begin
        w_load = w_expire;
        w_len  = C_SYNC_LEN;
      end
      CMP:     w_load = !w_last;
      default: w_load = 1'b0;
    endcase
  end

  osc_win_timer #(
    .C_WIN_W (C_WIN_W)
  ) u_timer (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .I_load   (w_load),
    .I_len    (w_len),
    .O_expire (w_expire)
  );

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_state     <= IDLE;
      r_chal      <= '0;
      r_win       <= '0;
      r_k         <= '0;
      r_resp_sh   <= '0;
      r_tie_sh    <= '0;
      O_sel_a     <= '0;
      O_sel_b     <= '0;
      O_osc_en    <= '0;
      O_cnt_rst_n <= 1'b0;
      O_busy      <= 1'b0;
      O_valid     <= 1'b0;
      O_resp      <= '0;
      O_tie       <= '0;
    end else begin
      O_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (I_start) begin
            r_chal      <= I_chal;
            r_win       <= (I_win_len == '0) ? C_WIN_W'(1) : I_win_len;
            r_k         <= '0;
            O_busy      <= 1'b1;
            O_sel_a     <= I_chal[SEL_W-1:0];
            O_sel_b     <= I_chal[2*SEL_W-1:SEL_W];
            O_osc_en    <= '0;
            O_cnt_rst_n <= 1'b0;
            r_state     <= SEL;
          end
        end
        SEL: begin
          if (w_expire) begin
            O_cnt_rst_n <= 1'b1;
            O_osc_en    <= w_en;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_expire) begin
            O_osc_en <= '0;
            r_state  <= STOP;
          end
        end
        STOP: begin
          // Falling counter reset makes the counters latch their value and clear.
          if (w_expire) begin
            O_cnt_rst_n <= 1'b0;
            r_state     <= LATCH;
          end
        end
        LATCH: begin
          if (w_expire) begin
            r_state <= CMP;
          end
        end
        CMP: begin
          r_resp_sh <= w_resp_nxt;
          r_tie_sh  <= w_tie_nxt;
          if (w_last) begin
            O_resp  <= w_resp_nxt;
            O_tie   <= w_tie_nxt;
            O_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k     <= r_k + K_W'(1);
            r_chal  <= w_chal_nxt;
            O_sel_a <= w_chal_nxt[SEL_W-1:0];
            O_sel_b <= w_chal_nxt[2*SEL_W-1:SEL_W];
            r_state <= SEL;
          end
        end
        DONE: begin
          O_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_osc_meas_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_osc_meas_ctrl : self-checking bench, vector table + random vs model   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_osc_meas_ctrl;

  localparam int NP     = 2;
  localparam int N_OSC  = 16;
  localparam int SEL_W  = 4;
  localparam int DW     = 24;
  localparam int WW     = 16;
  localparam int CH_W   = NP * 2 * SEL_W;
  localparam int SETTLE = 4;
  localparam int SYNC   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              I_start;
  logic [CH_W-1:0]   I_chal;
  logic [WW-1:0]     I_win_len;
  logic [DW-1:0]     I_cnt_a;
  logic [DW-1:0]     I_cnt_b;
  logic [SEL_W-1:0]  O_sel_a;
  logic [SEL_W-1:0]  O_sel_b;
  logic [N_OSC-1:0]  O_osc_en;
  logic              O_cnt_rst_n;
  logic              O_busy;
  logic              O_valid;
  logic [NP-1:0]     O_resp;
  logic [NP-1:0]     O_tie;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  osc_meas_ctrl #(
    .N_OSC    (N_OSC),
    .N_PAIRS  (NP),
    .C_DWIDTH (DW),
    .C_WIN_W  (WW),
    .C_SETTLE (SETTLE),
    .C_SYNC   (SYNC)
  ) dut (
    .I_clk       (clk),
    .I_rst       (rst_n),
    .I_start     (I_start),
    .I_chal      (I_chal),
    .I_win_len   (I_win_len),
    .I_cnt_a     (I_cnt_a),
    .I_cnt_b     (I_cnt_b),
    .O_sel_a     (O_sel_a),
    .O_sel_b     (O_sel_b),
    .O_osc_en    (O_osc_en),
    .O_cnt_rst_n (O_cnt_rst_n),
    .O_busy      (O_busy),
    .O_valid     (O_valid),
    .O_resp      (O_resp),
    .O_tie       (O_tie)
  );

  typedef struct {
    logic             busy;
    logic             valid;
    logic             rst_n;
    logic             rst_chk;
    logic             sel_chk;
    logic [N_OSC-1:0] en;
    logic [SEL_W-1:0] sa;
    logic [SEL_W-1:0] sb;
    int               pair;
  } cyc_t;

  typedef struct {
    logic [CH_W-1:0] chal;
    int              win;
    logic [DW-1:0]   ca [NP];
    logic [DW-1:0]   cb [NP];
    logic [NP-1:0]   resp;
    logic [NP-1:0]   tie;
  } vec_t;

  cyc_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_n(input cyc_t c, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(c);
  endtask

  // Expected cycle-by-cycle outputs derived from the phase rules alone.
  task automatic build_trace(input logic [CH_W-1:0] chal, input int win);
    cyc_t            c;
    logic [CH_W-1:0] sh;
    int              w;
    w = (win == 0) ? 1 : win;
    exp_q.delete();
    for (int k = 0; k < NP; k++) begin
      sh        = chal >> (2 * SEL_W * k);
      c.sa      = sh[SEL_W-1:0];
      c.sb      = sh[2*SEL_W-1:SEL_W];
      c.pair    = k;
      c.busy    = 1'b1;
      c.valid   = 1'b0;
      c.sel_chk = 1'b1;
      c.rst_chk = 1'b1;
      c.rst_n = 1'b0; c.en = '0;                                   push_n(c, SETTLE);
      c.rst_n = 1'b1; c.en = (16'd1 << c.sa) | (16'd1 << c.sb);    push_n(c, w);
      c.rst_n = 1'b1; c.en = '0;                                   push_n(c, SETTLE);
      c.rst_n = 1'b0;                                              push_n(c, SYNC);
      c.rst_chk = 1'b0;                                            push_n(c, 1);
    end
    c.sel_chk = 1'b0;
    c.rst_chk = 1'b0;
    c.en      = '0;
    c.valid   = 1'b1;                push_n(c, 1);
    c.valid   = 1'b0; c.busy = 1'b0; push_n(c, 1);
  endtask

  function automatic logic [NP-1:0] model_gt(input logic [DW-1:0] ca [NP], input logic [DW-1:0] cb [NP]);
    logic [NP-1:0] r;
    for (int k = 0; k < NP; k++) r[k] = (ca[k] > cb[k]);
    return r;
  endfunction

  function automatic logic [NP-1:0] model_eq(input logic [DW-1:0] ca [NP], input logic [DW-1:0] cb [NP]);
    logic [NP-1:0] r;
    for (int k = 0; k < NP; k++) r[k] = (ca[k] == cb[k]);
    return r;
  endfunction

  task automatic run_txn(input string tag, input logic [CH_W-1:0] chal, input int win,
                         input logic [DW-1:0] ca [NP], input logic [DW-1:0] cb [NP],
                         input logic [NP-1:0] er, input logic [NP-1:0] et, input bit noise);
    int            bad_t;
    string         bad_s;
    logic [NP-1:0] d_resp, d_tie, h_resp, h_tie;
    cyc_t          e;
    build_trace(chal, win);
    bad_t = -1;
    bad_s = "";
    @(negedge clk);
    I_start   = 1'b1;
    I_chal    = chal;
    I_win_len = WW'(win);
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge clk);
      e = exp_q[t];
      if (bad_t < 0 &&
          ((O_busy !== e.busy) || (O_valid !== e.valid) || (O_osc_en !== e.en) ||
           (e.rst_chk && (O_cnt_rst_n !== e.rst_n)) ||
           (e.sel_chk && ((O_sel_a !== e.sa) || (O_sel_b !== e.sb))))) begin
        bad_t = t;
        bad_s = $sformatf("busy=%b valid=%b en=%h rst_n=%b sel=%h/%h vs busy=%b valid=%b en=%h rst_n=%b sel=%h/%h",
                          O_busy, O_valid, O_osc_en, O_cnt_rst_n, O_sel_a, O_sel_b,
                          e.busy, e.valid, e.en, e.rst_n, e.sa, e.sb);
      end
      if (t == exp_q.size() - 2) begin
        d_resp = O_resp;
        d_tie  = O_tie;
      end
      if (t == exp_q.size() - 1) begin
        h_resp = O_resp;
        h_tie  = O_tie;
      end
      I_cnt_a = ca[e.pair];
      I_cnt_b = cb[e.pair];
      if (noise && t < exp_q.size() - 2) begin
        I_start   = 1'($urandom_range(0, 1));
        I_chal    = CH_W'($urandom);
        I_win_len = WW'($urandom);
      end else begin
        I_start = 1'b0;
      end
    end
    n_checks++;
    if (bad_t >= 0) begin
      n_err++;
      $display("FAIL %s trace at cycle %0d: got %s", tag, bad_t, bad_s);
    end
    chk({tag, " resp"}, 64'(d_resp), 64'(er));
    chk({tag, " tie"}, 64'(d_tie), 64'(et));
    chk({tag, " hold"}, 64'({h_resp, h_tie}), 64'({er, et}));
  endtask

  // Measure phase lengths purely from the output waveform.
  task automatic measure(input int win);
    logic en_a [256];
    logic rn_a [256];
    logic v_a  [256];
    int   n, i, sel_l, run_l, stop_l, gap_l, run2_l, lc_l, vw, vtot;
    int   exp_run;
    exp_run = (win == 0) ? 1 : win;
    n = 0;
    @(negedge clk);
    I_start   = 1'b1;
    I_chal    = 16'h5476;
    I_win_len = WW'(win);
    I_cnt_a   = 24'd3;
    I_cnt_b   = 24'd4;
    for (int c = 0; c < 255; c++) begin
      @(negedge clk);
      I_start = 1'b0;
      en_a[n] = (O_osc_en != '0);
      rn_a[n] = O_cnt_rst_n;
      v_a[n]  = O_valid;
      n++;
      if (!O_busy) break;
    end
    chk($sformatf("w%0d finish", win), 64'(O_busy), 64'd0);
    i = 0;
    sel_l = 0;  while (i < n && !en_a[i] && !rn_a[i])          begin sel_l++;  i++; end
    run_l = 0;  while (i < n && en_a[i])                       begin run_l++;  i++; end
    stop_l = 0; while (i < n && rn_a[i] && !en_a[i])           begin stop_l++; i++; end
    gap_l = 0;  while (i < n && !rn_a[i] && !en_a[i] && !v_a[i]) begin gap_l++; i++; end
    run2_l = 0; while (i < n && en_a[i])                       begin run2_l++; i++; end
    while (i < n && rn_a[i] && !en_a[i]) i++;
    lc_l = 0;   while (i < n && !rn_a[i] && !v_a[i])           begin lc_l++;   i++; end
    vw = 0;     while (i < n && v_a[i])                        begin vw++;     i++; end
    vtot = 0;
    for (int j = 0; j < n; j++) if (v_a[j]) vtot++;
    chk($sformatf("w%0d sel_len", win), 64'(sel_l), 64'(SETTLE));
    chk($sformatf("w%0d run_len", win), 64'(run_l), 64'(exp_run));
    chk($sformatf("w%0d stop_len", win), 64'(stop_l), 64'(SETTLE));
    chk($sformatf("w%0d latch_cmp_sel", win), 64'(gap_l), 64'(SYNC + 1 + SETTLE));
    chk($sformatf("w%0d run2_len", win), 64'(run2_l), 64'(exp_run));
    chk($sformatf("w%0d latch_cmp", win), 64'(lc_l), 64'(SYNC + 1));
    chk($sformatf("w%0d valid_width", win), 64'(vw), 64'd1);
    chk($sformatf("w%0d valid_count", win), 64'(vtot), 64'd1);
  endtask

  task automatic reset_abort();
    int  rises, vcnt;
    bit  prev, cur;
    rises = 0;
    prev  = 1'b0;
    @(negedge clk);
    I_start   = 1'b1;
    I_chal    = 16'h7654;
    I_win_len = 16'd8;
    for (int c = 0; c < 200 && rises < 2; c++) begin
      @(negedge clk);
      I_start = 1'b0;
      cur = (O_osc_en != '0);
      if (cur && !prev) rises++;
      prev = cur;
    end
    chk("abort reached pair1 RUN", 64'(rises), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort async outputs", 64'({O_busy, O_valid, O_cnt_rst_n, O_osc_en, O_resp, O_tie}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (O_valid || O_busy) vcnt++;
    end
    chk("abort no valid/busy", 64'(vcnt), 64'd0);
  endtask

  vec_t vt [5];

  initial begin
    logic [DW-1:0]   ra [NP];
    logic [DW-1:0]   rb [NP];
    logic [CH_W-1:0] rc, sh;
    int              rw;

    vt[0].chal = 16'h3210; vt[0].win = 10;
    vt[0].ca = '{24'd100, 24'd50};      vt[0].cb = '{24'd90, 24'd60};
    vt[0].resp = 2'b01; vt[0].tie = 2'b00;
    vt[1].chal = 16'h7754; vt[1].win = 6;
    vt[1].ca = '{24'd10, 24'd33};       vt[1].cb = '{24'd20, 24'd33};
    vt[1].resp = 2'b00; vt[1].tie = 2'b10;
    vt[2].chal = 16'hEF01; vt[2].win = 0;
    vt[2].ca = '{24'hFFFFFF, 24'd0};    vt[2].cb = '{24'hFFFFFE, 24'd1};
    vt[2].resp = 2'b01; vt[2].tie = 2'b00;
    vt[3].chal = 16'h9A3C; vt[3].win = 5;
    vt[3].ca = '{24'd5, 24'd7};         vt[3].cb = '{24'd5, 24'd6};
    vt[3].resp = 2'b10; vt[3].tie = 2'b01;
    vt[4].chal = 16'h1234; vt[4].win = 3;
    vt[4].ca = '{24'd0, 24'h800000};    vt[4].cb = '{24'd0, 24'h7FFFFF};
    vt[4].resp = 2'b10; vt[4].tie = 2'b01;

    rst_n     = 1'b0;
    I_start   = 1'b0;
    I_chal    = '0;
    I_win_len = '0;
    I_cnt_a   = '0;
    I_cnt_b   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({O_sel_a, O_sel_b, O_osc_en, O_cnt_rst_n, O_busy, O_valid, O_resp, O_tie}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 64'({O_busy, O_valid, O_osc_en}), 64'd0);

    for (int v = 0; v < 5; v++)
      run_txn($sformatf("vec%0d", v), vt[v].chal, vt[v].win, vt[v].ca, vt[v].cb,
              vt[v].resp, vt[v].tie, 1'b0);

    measure(5);
    measure(0);

    for (int r = 0; r < 16; r++) begin
      rc = CH_W'($urandom);
      rw = int'($urandom_range(0, 12));
      for (int k = 0; k < NP; k++) begin
        sh    = rc >> (2 * SEL_W * k);
        ra[k] = DW'($urandom);
        rb[k] = ($urandom_range(0, 3) == 0) ? ra[k] : DW'($urandom);
        if (sh[SEL_W-1:0] == sh[2*SEL_W-1:SEL_W]) rb[k] = ra[k];
      end
      run_txn($sformatf("rnd%0d", r), rc, rw, ra, rb, model_gt(ra, rb), model_eq(ra, rb), 1'b1);
    end

    reset_abort();
    run_txn("post_abort", vt[0].chal, vt[0].win, vt[0].ca, vt[0].cb, vt[0].resp, vt[0].tie, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
